fifo_param: RTL and testbench

//  Parametrised synchronous FIFO for the PCIe transaction-layer datapath.

---
 rtl/fifo_param.sv | 100 ++++++++++
 tb/tb_fifo_param.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read, occupancy count,
// run-time almost-full/almost-empty thresholds and a sticky overflow/underflow error.
module fifo_param #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AW         = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [AW:0]           th_afull,
  input  logic [AW:0]           th_aempty,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [AW:0]           fifo_count,
  output logic                  error
);

  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  error_q, error_d;
  logic                  wr_en, rd_en;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // When full, a simultaneous pop frees the slot being written this cycle.
  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    error_d    = error_q | (push & full & ~pop) | (pop & empty);

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem[rd_ptr_q];
      valid_d    = 1'b1;
    end

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= data_in;
    end
  end

  assign almost_full  = (count_q >= th_afull);
  assign almost_empty = (count_q <= th_aempty);
  assign fifo_count   = count_q;
  assign data_out     = data_out_q;
  assign valid_out    = valid_q;
  assign error        = error_q;

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (DATA_WIDTH=10, DEPTH=8).
module tb_fifo_param;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [9:0] data_in;
  logic [3:0] th_afull;
  logic [3:0] th_aempty;
  logic [9:0] data_out;
  logic       valid_out;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fifo_count;
  logic       error;

  int vecs = 0;
  int errs = 0;

  fifo_param #(
    .DATA_WIDTH(10),
    .DEPTH     (8),
    .AW        (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .data_in     (data_in),
    .th_afull    (th_afull),
    .th_aempty   (th_aempty),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .fifo_count  (fifo_count),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply one cycle of stimulus; returns 1 time unit after the rising edge.
  task automatic cycle(input logic p, input logic q, input logic [9:0] d);
    push    = p;
    pop     = q;
    data_in = d;
    @(posedge clk);
    #1;
    push    = 1'b0;
    pop     = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; push = 1'b1; pop = 1'b0; data_in = 10'h005;
    th_afull = 4'd6; th_aempty = 4'd2;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (fifo_count !== 4'd0) begin errs++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty: got %b expected 1", empty); end
    vecs++; if (full !== 1'b0) begin errs++; $display("FAIL reset_full: got %b expected 0", full); end
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", valid_out); end
    vecs++; if (data_out !== 10'h000) begin errs++; $display("FAIL reset_data: got %h expected 000", data_out); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL reset_error: got %b expected 0", error); end
    vecs++; if (almost_empty !== 1'b1) begin errs++; $display("FAIL reset_aempty: got %b expected 1", almost_empty); end
    vecs++; if (almost_full !== 1'b0) begin errs++; $display("FAIL reset_afull: got %b expected 0", almost_full); end
    push = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 10'(i));
    vecs++; if (full !== 1'b1) begin errs++; $display("FAIL fill_full: got %b expected 1", full); end
    vecs++; if (fifo_count !== 4'd8) begin errs++; $display("FAIL fill_count: got %0d expected 8", fifo_count); end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 10'h000);
      vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL drain_valid[%0d]: got %b expected 1", i, valid_out); end
      vecs++; if (data_out !== 10'(i)) begin errs++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 10'(i)); end
    end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL drain_empty: got %b expected 1", empty); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL drain_error: got %b expected 0", error); end
    cycle(1'b0, 1'b0, 10'h000);
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL idle_valid: got %b expected 0", valid_out); end
  endtask

  task automatic test_thresholds();
    th_afull = 4'd6; th_aempty = 4'd2;
    for (int n = 1; n <= 8; n++) begin
      cycle(1'b1, 1'b0, 10'(16 + n));
      vecs++; if (fifo_count !== 4'(n)) begin errs++; $display("FAIL th_count[%0d]: got %0d expected %0d", n, fifo_count, n); end
      vecs++; if (almost_empty !== (n <= 2)) begin errs++; $display("FAIL th_aempty[%0d]: got %b expected %b", n, almost_empty, (n <= 2)); end
      vecs++; if (almost_full !== (n >= 6)) begin errs++; $display("FAIL th_afull[%0d]: got %b expected %b", n, almost_full, (n >= 6)); end
      if (n == 4) begin
        th_afull = 4'd3;
        #1;
        vecs++; if (almost_full !== 1'b1) begin errs++; $display("FAIL th_change: got %b expected 1", almost_full); end
        th_afull = 4'd9;
        #1;
        vecs++; if (almost_full !== 1'b0) begin errs++; $display("FAIL th_over_depth: got %b expected 0", almost_full); end
        th_afull = 4'd6;
      end
    end
    th_afull = 4'd9;
    #1;
    vecs++; if (almost_full !== 1'b0) begin errs++; $display("FAIL th_over_full: got %b expected 0", almost_full); end
    th_afull = 4'd6;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b1, 10'h000);
      vecs++; if (data_out !== 10'(16 + k)) begin errs++; $display("FAIL th_data[%0d]: got %h expected %h", k, data_out, 10'(16 + k)); end
      vecs++; if (almost_empty !== ((8 - k) <= 2)) begin errs++; $display("FAIL th_drain_ae[%0d]: got %b expected %b", k, almost_empty, ((8 - k) <= 2)); end
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 10'(32 + i));
    cycle(1'b1, 1'b0, 10'h3FF);
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL ovf_error: got %b expected 1", error); end
    vecs++; if (fifo_count !== 4'd8) begin errs++; $display("FAIL ovf_count: got %0d expected 8", fifo_count); end
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 10'h000);
      vecs++; if (data_out !== 10'(32 + i)) begin errs++; $display("FAIL ovf_data[%0d]: got %h expected %h", i, data_out, 10'(32 + i)); end
    end
    cycle(1'b0, 1'b1, 10'h000);
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL udf_valid: got %b expected 0", valid_out); end
    vecs++; if (data_out !== 10'h028) begin errs++; $display("FAIL udf_hold: got %h expected 028", data_out); end
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL udf_error: got %b expected 1", error); end
    vecs++; if (fifo_count !== 4'd0) begin errs++; $display("FAIL udf_count: got %0d expected 0", fifo_count); end
    pulse_reset();
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL err_clear: got %b expected 0", error); end
    // Underflow alone, on a clean error flag.
    cycle(1'b0, 1'b1, 10'h000);
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL udf_only_error: got %b expected 1", error); end
    pulse_reset();
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 10'(48 + i));
    cycle(1'b1, 1'b1, 10'h039);
    vecs++; if (fifo_count !== 4'd8) begin errs++; $display("FAIL sim_full_count: got %0d expected 8", fifo_count); end
    vecs++; if (data_out !== 10'h031) begin errs++; $display("FAIL sim_full_data: got %h expected 031", data_out); end
    vecs++; if (valid_out !== 1'b1) begin errs++; $display("FAIL sim_full_valid: got %b expected 1", valid_out); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL sim_full_error: got %b expected 0", error); end
    for (int i = 2; i <= 9; i++) begin
      cycle(1'b0, 1'b1, 10'h000);
      vecs++; if (data_out !== 10'(48 + i)) begin errs++; $display("FAIL sim_order[%0d]: got %h expected %h", i, data_out, 10'(48 + i)); end
    end
    cycle(1'b1, 1'b1, 10'h03A);
    vecs++; if (fifo_count !== 4'd1) begin errs++; $display("FAIL sim_empty_count: got %0d expected 1", fifo_count); end
    vecs++; if (valid_out !== 1'b0) begin errs++; $display("FAIL sim_empty_valid: got %b expected 0", valid_out); end
    vecs++; if (error !== 1'b1) begin errs++; $display("FAIL sim_empty_error: got %b expected 1", error); end
    cycle(1'b0, 1'b1, 10'h000);
    vecs++; if (data_out !== 10'h03A) begin errs++; $display("FAIL sim_empty_data: got %h expected 03a", data_out); end
    pulse_reset();
  endtask

  task automatic test_wrap_reset();
    logic [9:0] q[$];
    logic [9:0] exp;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 10'(80 + i));
      q.push_back(10'(80 + i));
    end
    // Net-zero pattern per group of four: count oscillates 4..5, pointers wrap.
    for (int i = 0; i < 20; i++) begin
      logic p, r;
      p = (i % 4 != 3);
      r = (i % 4 != 0);
      exp = 10'h000;
      if (r) exp = q.pop_front();
      if (p) q.push_back(10'(96 + i));
      cycle(p, r, 10'(96 + i));
      if (r) begin
        vecs++; if (valid_out !== 1'b1 || data_out !== exp) begin errs++; $display("FAIL wrap_data[%0d]: got %b/%h expected 1/%h", i, valid_out, data_out, exp); end
      end
    end
    vecs++; if (fifo_count !== 4'(q.size())) begin errs++; $display("FAIL wrap_count: got %0d expected %0d", fifo_count, q.size()); end
    cycle(1'b1, 1'b0, 10'h1FF);
    vecs++; if (fifo_count !== 4'd5) begin errs++; $display("FAIL pre_reset_count: got %0d expected 5", fifo_count); end
    #3 reset = 1'b0;
    #1;
    vecs++; if (fifo_count !== 4'd0) begin errs++; $display("FAIL async_count: got %0d expected 0", fifo_count); end
    vecs++; if (empty !== 1'b1) begin errs++; $display("FAIL async_empty: got %b expected 1", empty); end
    vecs++; if (error !== 1'b0) begin errs++; $display("FAIL async_error: got %b expected 0", error); end
    #1 reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_thresholds();
    test_overflow();
    test_simultaneous();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
